// File: rtl/press_classifier.sv
// Classifies debounced button presses into SHORT, LONG and DOUBLE events.
// Each event goes into a one-entry output buffer with a valid/ready handshake.
module press_classifier #(
  parameter int unsigned CNT_W         = 26,
  parameter int unsigned LONG_TICKS    = 50_000_000,
  parameter int unsigned DBL_GAP_TICKS = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_down,
  input  logic       pb_up,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overflow,
  output logic       busy
);

  localparam logic [1:0] CODE_SHORT  = 2'b01;
  localparam logic [1:0] CODE_LONG   = 2'b10;
  localparam logic [1:0] CODE_DOUBLE = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    WAIT_REL
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             emit;
  logic [1:0]       emit_code;
  logic             dn, up;

  // Simultaneous down/up pulses cancel out and are treated as no input.
  assign dn      = pb_down & ~pb_up;
  assign up      = pb_up & ~pb_down;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    emit       = 1'b0;
    emit_code  = 2'b00;
    unique case (state)
      IDLE: begin
        if (dn) begin
          state_next = PRESS1;
          cnt_next   = '0;
        end
      end
      PRESS1: begin
        if (up) begin
          state_next = GAP;
          cnt_next   = '0;
        end else if (cnt == LONG_LAST) begin
          state_next = WAIT_REL;
          emit       = 1'b1;
          emit_code  = CODE_LONG;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      GAP: begin
        if (dn) begin
          state_next = PRESS2;
        end else if (cnt == GAP_LAST) begin
          state_next = IDLE;
          emit       = 1'b1;
          emit_code  = CODE_SHORT;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESS2: begin
        if (up) begin
          state_next = IDLE;
          emit       = 1'b1;
          emit_code  = CODE_DOUBLE;
        end
      end
      WAIT_REL: begin
        if (up) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One-entry output buffer; a new event while full and not accepted is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid    <= 1'b0;
      evt_code     <= 2'b00;
      evt_overflow <= 1'b0;
    end else begin
      evt_overflow <= 1'b0;
      if (emit) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_code  <= emit_code;
        end else begin
          evt_overflow <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG_TICKS=8, DBL_GAP_TICKS=4.
module tb_press_classifier;

  logic       clk;
  logic       rst_n;
  logic       pb_down;
  logic       pb_up;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_overflow;
  logic       busy;

  int n_cmp;
  int n_err;

  press_classifier #(
    .CNT_W        (8),
    .LONG_TICKS   (8),
    .DBL_GAP_TICKS(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb_down     (pb_down),
    .pb_up       (pb_up),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ready   (evt_ready),
    .evt_overflow(evt_overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance past one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive pulses that the next rising edge samples, then clear them.
  task automatic step(input logic dn, input logic up);
    pb_down = dn;
    pb_up   = up;
    tick();
    pb_down = 1'b0;
    pb_up   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pb_down = 1'b0; pb_up = 1'b0; evt_ready = 1'b1;
    #1;
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_cmp++; if (evt_code !== 2'b00) begin n_err++; $display("FAIL reset_code: got %b want 00", evt_code); end
    n_cmp++; if (evt_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", evt_overflow); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (evt_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_release: valid=%b busy=%b want 0 0", evt_valid, busy); end
  endtask

  task automatic test_both_noop();
    step(1'b1, 1'b1);
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL both_noop_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_short();
    step(1'b1, 1'b0);                 // edge 0
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL short_busy: got %b want 1", busy); end
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1);                 // edge 3
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL short_early: valid=%b after edge6 want 0", evt_valid); end
    step(1'b0, 1'b0);                 // edge 7
    n_cmp++; if (evt_valid !== 1'b1 || evt_code !== 2'b01) begin n_err++; $display("FAIL short_emit: valid=%b code=%b want 1 01", evt_valid, evt_code); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL short_idle: busy=%b want 0", busy); end
    step(1'b0, 1'b0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL short_clear: valid=%b want 0", evt_valid); end
  endtask

  task automatic test_long();
    int extra;
    extra = 0;
    step(1'b1, 1'b0);                 // edge 0
    for (int e = 1; e <= 7; e++) step(1'b0, 1'b0);
    n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL long_early: valid=%b after edge7 want 0", evt_valid); end
    step(1'b0, 1'b0);                 // edge 8
    n_cmp++; if (evt_valid !== 1'b1 || evt_code !== 2'b10) begin n_err++; $display("FAIL long_emit: valid=%b code=%b want 1 10", evt_valid, evt_code); end
    step(1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL long_waitrel: busy=%b want 1", busy); end
    for (int e = 10; e <= 19; e++) begin
      step(1'b0, 1'b0);
      if (evt_valid) extra++;
    end
    step(1'b0, 1'b1);                 // edge 20
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL long_release: busy=%b want 0", busy); end
    for (int e = 21; e <= 32; e++) begin
      step(1'b0, 1'b0);
      if (evt_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL long_no_second: extra valid cycles=%0d want 0", extra); end
  endtask

  task automatic test_double();
    int nvalid, at;
    logic [1:0] code;
    nvalid = 0; at = -1; code = 2'b00;
    for (int e = 0; e <= 40; e++) begin
      step(e == 0 || e == 4, e == 2 || e == 30);
      if (evt_valid) begin nvalid++; at = e; code = evt_code; end
    end
    n_cmp++; if (nvalid !== 1) begin n_err++; $display("FAIL double_count: got %0d events want 1", nvalid); end
    n_cmp++; if (code !== 2'b11) begin n_err++; $display("FAIL double_code: got %b want 11", code); end
    n_cmp++; if (at !== 30) begin n_err++; $display("FAIL double_edge: got %0d want 30", at); end
  endtask

  task automatic test_tie();
    int nvalid, at;
    logic [1:0] code;
    logic busy13;
    nvalid = 0; at = -1; code = 2'b00; busy13 = 1'b0;
    for (int e = 0; e <= 24; e++) begin
      step(e == 0 || e == 12, e == 8 || e == 15);
      if (e == 13) busy13 = busy;
      if (evt_valid) begin nvalid++; at = e; code = evt_code; end
    end
    n_cmp++; if (busy13 !== 1'b1) begin n_err++; $display("FAIL tie_press2_busy: got %b want 1", busy13); end
    n_cmp++; if (nvalid !== 1) begin n_err++; $display("FAIL tie_count: got %0d events want 1", nvalid); end
    n_cmp++; if (code !== 2'b11) begin n_err++; $display("FAIL tie_code: got %b want 11", code); end
    n_cmp++; if (at !== 15) begin n_err++; $display("FAIL tie_edge: got %0d want 15", at); end
  endtask

  task automatic test_overflow();
    int n_ovf, ovf_at;
    logic v5, v19;
    logic [1:0] c19;
    n_ovf = 0; ovf_at = -1; v5 = 1'b0; v19 = 1'b0; c19 = 2'b00;
    for (int e = 0; e <= 22; e++) begin
      evt_ready = (e >= 20);
      step(e == 0 || e == 10, e == 1 || e == 11);
      if (e == 5) v5 = evt_valid;
      if (e == 19) begin v19 = evt_valid; c19 = evt_code; end
      if (e == 20) begin
        n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_clear: valid=%b want 0", evt_valid); end
      end
      if (evt_overflow) begin n_ovf++; ovf_at = e; end
    end
    evt_ready = 1'b1;
    n_cmp++; if (v5 !== 1'b1) begin n_err++; $display("FAIL ovf_first: valid=%b want 1", v5); end
    n_cmp++; if (v19 !== 1'b1 || c19 !== 2'b01) begin n_err++; $display("FAIL ovf_hold: valid=%b code=%b want 1 01", v19, c19); end
    n_cmp++; if (n_ovf !== 1) begin n_err++; $display("FAIL ovf_pulses: got %0d want 1", n_ovf); end
    n_cmp++; if (ovf_at !== 15) begin n_err++; $display("FAIL ovf_edge: got %0d want 15", ovf_at); end
  endtask

  task automatic test_reset_mid();
    int bad_busy, bad_valid;
    logic busy4;
    bad_busy = 0; bad_valid = 0; busy4 = 1'b0;
    for (int e = 0; e <= 22; e++) begin
      if (e == 5) begin
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_async: busy=%b want 0", busy); end
      end
      if (e == 7) rst_n = 1'b1;
      step(e == 0, e == 10);
      if (e == 4) busy4 = busy;
      if (e >= 5 && busy) bad_busy++;
      if (evt_valid) bad_valid++;
    end
    n_cmp++; if (busy4 !== 1'b1) begin n_err++; $display("FAIL rstmid_press: busy=%b want 1", busy4); end
    n_cmp++; if (bad_busy !== 0) begin n_err++; $display("FAIL rstmid_busy: busy cycles=%0d want 0", bad_busy); end
    n_cmp++; if (bad_valid !== 0) begin n_err++; $display("FAIL rstmid_valid: valid cycles=%0d want 0", bad_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_both_noop();
    test_short();
    test_long();
    test_double();
    test_tie();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter CNT_W, default 26, the width of the internal tick counter.
REQ-002 SHALL have parameter LONG_TICKS, default 50_000_000, the number of hold cycles that makes a long press.
REQ-003 SHALL have parameter DBL_GAP_TICKS, default 25_000_000, the maximum release gap for a double press.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port pb_down, input, 1 bit: one-cycle pulse from the debouncer when the button goes down; synchronous to clk.
REQ-007 SHALL have port pb_up, input, 1 bit: one-cycle pulse from the debouncer when the button is released; synchronous to clk.
REQ-008 SHALL have port evt_valid, output, 1 bit: a classified event is pending.
REQ-009 SHALL have port evt_code, output, 2 bits: event code; 01 SHORT, 10 LONG, 11 DOUBLE, 00 never presented while valid.
REQ-010 SHALL have port evt_ready, input, 1 bit: the consumer accepts the pending event.
REQ-011 SHALL have port evt_overflow, output, 1 bit: one-cycle pulse when an event is dropped.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, PRESS1, GAP, PRESS2 and WAIT_REL, plus a CNT_W-bit counter cnt that saturates at all-ones.
REQ-014 IDLE: pb_down SHALL move to PRESS1 with cnt=0; all other inputs are ignored.
REQ-015 PRESS1: pb_up SHALL move to GAP with cnt=0.
REQ-016 PRESS1: else, when cnt==LONG_TICKS-1, SHALL emit LONG and move to WAIT_REL.
REQ-017 PRESS1: else SHALL increment cnt.
REQ-018 PRESS1: pb_up SHALL win over the LONG threshold when both occur on the same edge.
REQ-019 GAP: pb_down SHALL move to PRESS2.
REQ-020 GAP: else, when cnt==DBL_GAP_TICKS-1, SHALL emit SHORT and move to IDLE.
REQ-021 GAP: else SHALL increment cnt; pb_down SHALL win over timeout on the same edge.
REQ-022 PRESS2: pb_up SHALL emit DOUBLE and move to IDLE; there is no timeout and hold length is ignored.
REQ-023 WAIT_REL: pb_up SHALL move to IDLE with no event.
REQ-024 pb_down and pb_up asserted together SHALL be a no-op in every state.
REQ-025 "Emit" SHALL register the event on the same edge as the state transition: no added latency.
REQ-026 LONG: evt_valid SHALL rise at the LONG_TICKS-th edge after the edge sampling pb_down.
REQ-027 SHORT: evt_valid SHALL rise at the DBL_GAP_TICKS-th edge after the edge sampling pb_up.
REQ-028 Output buffer holds one entry; evt_valid and evt_code SHALL hold stable until an edge with evt_valid&evt_ready.
REQ-029 On an edge with evt_valid&evt_ready and no new emit, evt_valid SHALL clear.
REQ-030 Emit with the buffer empty, or with evt_ready high on the same edge, SHALL load the new code and keep evt_valid=1.
REQ-031 Emit with evt_valid=1 and evt_ready=0 SHALL drop the new event, keep the old one, and pulse evt_overflow for one cycle.
REQ-032 evt_ready while evt_valid=0 SHALL have no effect.
REQ-033 Parameters SHALL satisfy 2 <= DBL_GAP_TICKS and LONG_TICKS <= 2^CNT_W-1; other values are unsupported.

Reset
REQ-034 rst_n low SHALL immediately force state=IDLE, cnt=0, evt_valid=0, evt_code=00, evt_overflow=0, busy=0.
REQ-035 Reset mid-press SHALL discard the in-progress classification; after release, a pb_up arriving in IDLE SHALL be ignored.
REQ-036 Reset deassertion SHALL take effect at the next clk edge with no spurious event.

Verification (LONG_TICKS=8, DBL_GAP_TICKS=4, evt_ready=1 unless stated)
REQ-037 pb_down@edge0, pb_up@edge3, nothing after -> evt_code=01 valid after edge7 for 1 cycle; busy low after edge7.
REQ-038 pb_down@0, no pb_up -> evt_code=10 valid after edge8; pb_up@20 -> IDLE, no second event.
REQ-039 pb_down@0, pb_up@2, pb_down@4, pb_up@30 -> single evt_code=11 after edge30, no SHORT emitted.
REQ-040 pb_up on the same edge cnt hits 7 in PRESS1 -> goes GAP, no LONG; pb_down on the GAP timeout edge -> PRESS2.
REQ-041 evt_ready=0, two SHORT presses -> first code held, evt_overflow one-cycle pulse at the second emit; evt_ready=1 then clears evt_valid.
REQ-042 rst_n low at cycle 5 of a PRESS1 hold, released, pb_up later -> no event, busy=0, evt_valid=0 throughout.
